// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, stop bit.
// One bit per clock; TX_OUT and Busy are registered and reflect the state being entered.
module uart_tx #(
    parameter int unsigned width = 8
) (
    input  logic             CLK_TX,
    input  logic             RST_TX,
    input  logic [width-1:0] P_DATA_TX,
    input  logic             DATA_VALID_TX,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic             TX_OUT,
    output logic             Busy
);

    localparam int unsigned idx_w = (width > 1) ? $clog2(width) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [idx_w-1:0] idx, idx_nxt;
    logic [width-1:0] data_r, data_nxt;
    logic             par_en_r, par_en_nxt;
    logic             par_typ_r, par_typ_nxt;
    logic             tx_nxt, busy_nxt;
    logic             parity_bit_c;

    // Odd parity is the complement of the even parity bit.
    assign parity_bit_c = (^data_r) ^ par_typ_r;

    // State, frame capture and registered outputs.
    always_ff @(posedge CLK_TX or posedge RST_TX) begin
        if (RST_TX) begin
            state     <= IDLE;
            idx       <= '0;
            data_r    <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            data_r    <= data_nxt;
            par_en_r  <= par_en_nxt;
            par_typ_r <= par_typ_nxt;
            TX_OUT    <= tx_nxt;
            Busy      <= busy_nxt;
        end
    end

    // Next state and the line value for the bit about to be driven.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        data_nxt    = data_r;
        par_en_nxt  = par_en_r;
        par_typ_nxt = par_typ_r;
        tx_nxt      = 1'b1;
        busy_nxt    = 1'b0;

        case (state)
            // The stop cycle ends at the same edge that may accept the next frame.
            IDLE, STOP: begin
                if (DATA_VALID_TX) begin
                    state_nxt   = START;
                    idx_nxt     = '0;
                    data_nxt    = P_DATA_TX;
                    par_en_nxt  = PAR_EN;
                    par_typ_nxt = PAR_TYP;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                state_nxt = DATA;
                idx_nxt   = '0;
                tx_nxt    = data_r[0];
                busy_nxt  = 1'b1;
            end
            DATA: begin
                busy_nxt = 1'b1;
                if (idx == last_idx) begin
                    if (par_en_r) begin
                        state_nxt = PARITY;
                        tx_nxt    = parity_bit_c;
                    end else begin
                        state_nxt = STOP;
                    end
                end else begin
                    idx_nxt = idx + idx_w'(1);
                    tx_nxt  = data_r[idx_nxt];
                end
            end
            PARITY: begin
                state_nxt = STOP;
                busy_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame bit sequences, Busy window, mid-frame stimulus and reset.
module tb_uart_tx;

    logic       CLK_TX;
    logic       RST_TX;
    logic [7:0] P_DATA_TX;
    logic       DATA_VALID_TX;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int errs   = 0;
    int checks = 0;

    uart_tx #(.width(8)) dut (
        .CLK_TX       (CLK_TX),
        .RST_TX       (RST_TX),
        .P_DATA_TX    (P_DATA_TX),
        .DATA_VALID_TX(DATA_VALID_TX),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .TX_OUT       (TX_OUT),
        .Busy         (Busy)
    );

    initial begin
        CLK_TX = 1'b0;
        forever #5 CLK_TX = ~CLK_TX;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present a word and hold valid across one edge (E0); returns #1 after E0.
    task automatic launch(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK_TX);
        P_DATA_TX     = d;
        PAR_EN        = pe;
        PAR_TYP       = pt;
        DATA_VALID_TX = 1'b1;
        @(posedge CLK_TX);
        #1;
        DATA_VALID_TX = 1'b0;
    endtask

    // Expected bits written first-bit-first as MSB of exp; optional mid-frame disturbance.
    task automatic check_frame(input string tag, input logic [10:0] exp, input int n,
                               input bit disturb);
        logic [10:0] e;
        e = exp;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s tx[%0d]", tag, k), 32'(TX_OUT), 32'(e[n-1-k]));
            check($sformatf("%s busy[%0d]", tag, k), 32'(Busy), 32'd1);
            if (disturb && k == 3) begin
                P_DATA_TX     = 8'h3C;
                PAR_TYP       = ~PAR_TYP;
                DATA_VALID_TX = 1'b1;
            end
            if (disturb && k == 4) DATA_VALID_TX = 1'b0;
            @(posedge CLK_TX);
            #1;
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            check($sformatf("%s tx[%0d]", tag, k), 32'(TX_OUT), 32'd1);
            check($sformatf("%s busy[%0d]", tag, k), 32'(Busy), 32'd0);
            @(posedge CLK_TX);
            #1;
        end
    endtask

    localparam logic [10:0] seq_a5_even = 11'b01010010101;
    localparam logic [10:0] seq_f4_none = 11'b00001011111;
    localparam logic [10:0] seq_f2_odd  = 11'b00100111101;

    initial begin
        RST_TX        = 1'b0;
        P_DATA_TX     = 8'h00;
        DATA_VALID_TX = 1'b0;
        PAR_EN        = 1'b0;
        PAR_TYP       = 1'b0;

        // Reset asserted between edges takes effect at once and holds.
        #2 RST_TX = 1'b1;
        #1;
        check("rst tx", 32'(TX_OUT), 32'd1);
        check("rst busy", 32'(Busy), 32'd0);
        repeat (2) @(posedge CLK_TX);
        #1;
        check("rst hold tx", 32'(TX_OUT), 32'd1);
        check("rst hold busy", 32'(Busy), 32'd0);
        @(negedge CLK_TX);
        RST_TX = 1'b0;
        @(posedge CLK_TX);
        #1;
        check_idle("post rst", 3);

        launch(8'hA5, 1'b1, 1'b0);
        check_frame("a5 even", seq_a5_even, 11, 1'b0);
        check_idle("a5 idle", 2);

        launch(8'hF4, 1'b0, 1'b0);
        check_frame("f4 nopar", seq_f4_none, 10, 1'b0);
        check_idle("f4 idle", 2);

        launch(8'hF2, 1'b1, 1'b1);
        check_frame("f2 odd", seq_f2_odd, 11, 1'b0);
        check_idle("f2 idle", 2);

        // Valid pulse with 0x3C and a parity-type flip during data bits are ignored.
        launch(8'hA5, 1'b1, 1'b0);
        check_frame("a5 disturbed", seq_a5_even, 11, 1'b1);
        check_idle("no 3c", 14);

        // Valid held high across the final edge starts the next frame there.
        launch(8'hF4, 1'b0, 1'b0);
        DATA_VALID_TX = 1'b1;
        P_DATA_TX     = 8'hF2;
        PAR_EN        = 1'b1;
        PAR_TYP       = 1'b1;
        check_frame("f4 first", seq_f4_none, 10, 1'b0);
        DATA_VALID_TX = 1'b0;
        check_frame("f2 b2b", seq_f2_odd, 11, 1'b0);
        check_idle("b2b idle", 2);

        // Reset during data bit 3 aborts the frame asynchronously.
        launch(8'hA5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK_TX);
            #1;
        end
        check("bit3 before rst", 32'(TX_OUT), 32'd0);
        check("busy before rst", 32'(Busy), 32'd1);
        #2 RST_TX = 1'b1;
        #1;
        check("midrst tx", 32'(TX_OUT), 32'd1);
        check("midrst busy", 32'(Busy), 32'd0);
        @(negedge CLK_TX);
        RST_TX = 1'b0;
        @(posedge CLK_TX);
        #1;
        check_idle("after midrst", 13);
        launch(8'hF4, 1'b0, 1'b0);
        check_frame("f4 after rst", seq_f4_none, 10, 1'b0);
        check_idle("final idle", 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
